seg7_scan_driver: RTL
=====================

Name: seg7_scan_driver

Overview:
Time-multiplexed driver for a common-anode multi-digit seven-segment display, on the output side of the board I/O path. Takes a packed hex value plus decimal points and scans the digits one at a time. Each digit is lit for a fixed on-time, and a blanking gap between digits suppresses ghosting. A snapshot of the inputs is taken once per frame so the displayed value never tears mid-scan.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
ON_CYCLES, 1000, clocks each digit's anode is active (>=1)
BLANK_CYCLES, 16, clocks with all anodes off between digits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
en  in  1  scan enable; 0 = display dark
digits  in  4*NUM_DIGITS  hex nibbles; digit i = digits[4i+3:4i], digit 0 rightmost
dp  in  NUM_DIGITS  decimal point request per digit, active-high
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point segment, active-low
an_n  out  NUM_DIGITS  digit anodes, active-low, at most one low at any time
frame_start  out  1  one-cycle pulse when a new snapshot is latched

Behaviour:
- All outputs are registered. Reset values: seg_n=7'h7F, dp_n=1, an_n=all ones, frame_start=0. Internal state: IDLE, idx=0, counter=0.
- FSM states:
  - IDLE: outputs dark.
  - BLANK: an_n all ones, seg_n=7'h7F, dp_n=1.
  - ON: an_n[idx]=0, seg_n=decode(snapshot digit idx), dp_n=~snapshot_dp[idx].
- IDLE->BLANK when en is sampled high. Entering BLANK with idx=0 latches digits/dp into the snapshot and pulses frame_start in the same cycle as the latch.
- BLANK lasts exactly BLANK_CYCLES clocks, then ON.
- ON lasts exactly ON_CYCLES clocks, then BLANK with idx+1. idx wraps from NUM_DIGITS-1 to 0, which starts a new frame.
- Frame period = NUM_DIGITS*(ON_CYCLES+BLANK_CYCLES) clocks.
- Start-up timing: en sampled high at edge k -> dark through edge k+BLANK_CYCLES; digit 0 lit from edge k+BLANK_CYCLES+1.
- en sampled low in any state -> next cycle IDLE, outputs dark, idx=0, counter=0. Re-enable always restarts at digit 0 with a fresh snapshot.
- Input changes between frame_start pulses have no visible effect.
- Decode table, active-low hex, 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E.
- Counter width: $clog2(max(ON_CYCLES,BLANK_CYCLES)+1). No overflow is possible.
- Illegal parameter values (NUM_DIGITS out of range, ON/BLANK_CYCLES<1) are caught by an elaboration-time check.

Optional Feature:
SEG7_LZB_EN (leading-zero blanking).
- Defined: zero digits above the most significant nonzero digit of the snapshot keep an_n all ones during their ON slot. Slot timing is unchanged. Digit 0 is always shown. A digit whose dp bit is set is never blanked.
- Undefined: every digit is lit in its slot.

Decomposition:
- Package seg7_pkg holds: the state enum (IDLE/BLANK/ON), the 16-entry segment encoding constants, and the SEG_OFF=7'h7F constant.
- One combinational sub-module, seg7_hex_decoder (4-bit in, 7-bit active-low out), instantiated once on the selected snapshot nibble.

Test Plan:
All scenarios use NUM_DIGITS=4, ON_CYCLES=8, BLANK_CYCLES=2.
1. Reset asserted mid-ON -> an_n=4'hF, seg_n=7'h7F, dp_n=1, frame_start=0 immediately (asynchronous reset).
2. en=1, digits=16'h1234:
   - first frame_start in the cycle BLANK is entered;
   - sequence an_n=1110/seg 19, 1101/30, 1011/24, 0111/79, each 8 clocks, with 2 dark clocks between;
   - frame_start every 40 clocks.
3. Change digits to 16'hABCD during digit-1 ON -> remainder of frame still shows 1,2; next frame shows D,C,B,A (21,46,03,08).
4. Drop en during digit-2 ON -> next cycle all dark. Re-raise en -> 2 dark clocks, then digit 0 lit, with a new frame_start.
5. dp=4'b0100, digits=16'h8888 -> dp_n=0 only while an_n=1011; seg_n=00 for all digits.
6. digits=16'h0050, dp=0:
   - with SEG7_LZB_EN: slots 3 and 2 stay an_n=1111; slot 1 shows 12, slot 0 shows 40; period still 40.
   - without the macro: all four slots lit (40,40,12,40 in digit order 3..0).

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the seven-segment scan driver.
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } seg7_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns; element 15 (F) is listed first.
    localparam logic [15:0][6:0] SEG_ENC = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_ENC[hex];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam int IW         = $clog2(NUM_DIGITS);

    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || ON_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("seg7_scan_driver: illegal NUM_DIGITS/ON_CYCLES/BLANK_CYCLES");
    end

    seg7_state_t             state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;

    logic [3:0] cur_nib;
    logic [6:0] cur_seg;
    logic       cur_hide;

    always_comb begin
        cur_nib = snap_digits[4*int'(idx) +: 4];
    end

    seg7_hex_decoder u_dec (
        .hex   (cur_nib),
        .seg_n (cur_seg)
    );

`ifdef SEG7_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    logic [NUM_DIGITS-1:0] hide;

    always_comb begin
        hide = '0;
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            hide[i] = !snap_dp[i] && ((snap_digits >> (4*i)) == '0);
        end
        cur_hide = hide[idx];
    end
`else
    always_comb begin
        cur_hide = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
            seg_n       <= SEG_OFF;
            dp_n        <= 1'b1;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (!en) begin
                state <= IDLE;
                idx   <= '0;
                cnt   <= '0;
                seg_n <= SEG_OFF;
                dp_n  <= 1'b1;
                an_n  <= '1;
            end else begin
                // Display outputs follow the state one clock behind, so a slot
                // spans exactly its state's duration, delayed by one cycle.
                if (state == ON && !cur_hide) begin
                    an_n  <= ~(NUM_DIGITS'(1) << idx);
                    seg_n <= cur_seg;
                    dp_n  <= ~snap_dp[idx];
                end else begin
                    an_n  <= '1;
                    seg_n <= SEG_OFF;
                    dp_n  <= 1'b1;
                end

                case (state)
                    IDLE: begin
                        state       <= BLANK;
                        idx         <= '0;
                        cnt         <= '0;
                        snap_digits <= digits;
                        snap_dp     <= dp;
                        frame_start <= 1'b1;
                    end
                    BLANK: begin
                        if (cnt == BLANK_LAST) begin
                            state <= ON;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ON: begin
                        if (cnt == ON_LAST) begin
                            state <= BLANK;
                            cnt   <= '0;
                            if (idx == LAST_IDX) begin
                                idx         <= '0;
                                snap_digits <= digits;
                                snap_dp     <= dp;
                                frame_start <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        idx   <= '0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
